// File: rtl/cpu_fsm_controller_if.sv
// Control-path bundle between the instruction sequencer and its driver/datapath.
// Latency: none, wires only.
// Backpressure: none; start is sampled only when the sequencer reports ready (w).
interface cpu_fsm_controller_if;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        write;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   // Sequencer side: takes start/instruction, drives datapath controls.
   modport slave (
      input  s, load, in,
      output w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
             asel, bsel, shift, ALUop, sximm8, sximm5
   );

   // Driver side: issues instructions and observes the controls.
   modport master (
      output s, load, in,
      input  w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
             asel, bsel, shift, ALUop, sximm8, sximm5
   );
endinterface

// File: rtl/cpu_fsm_controller.sv
// Moore instruction sequencer: holds the IR and steps a 16-bit datapath through MOV/MVN/ADD/CMP/AND.
// Latency: 3 edges (MOV imm), 5 (MOV reg/MVN/CMP), 6 (ADD/AND), 2 (undefined) from start to w=1.
// Backpressure: w=1 only in WAIT; s and load are ignored in every other state.
module cpu_fsm_controller (
   input  logic                  clk,
   input  logic                  rst_n,
   cpu_fsm_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  sh;
   logic        is_mov_imm, is_mov_reg, is_mvn, is_add, is_cmp, is_and;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
   assign is_add     = (opcode == 3'b101) && (op == 2'b00);
   assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
   assign is_and     = (opcode == 3'b101) && (op == 2'b10);

   // Immediates follow the IR directly so they are valid in every state.
   assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

   // State and IR registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_WAIT;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // IR accepts a new word only while idle so an instruction cannot be corrupted mid-flight.
   always_comb begin
      ir_d = ir_q;
      if (bus.load && (state_q == S_WAIT)) begin
         ir_d = bus.in;
      end
   end

   // Next-state and Moore output decode; every control defaults to 0.
   always_comb begin
      state_d      = state_q;
      bus.w        = 1'b0;
      bus.readnum  = 3'd0;
      bus.writenum = 3'd0;
      bus.vsel     = 2'b00;
      bus.loada    = 1'b0;
      bus.loadb    = 1'b0;
      bus.loadc    = 1'b0;
      bus.loads    = 1'b0;
      bus.write    = 1'b0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.shift    = 2'b00;
      bus.ALUop    = 2'b00;

      case (state_q)
         S_WAIT: begin
            bus.w = 1'b1;
            if (bus.s) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)                     state_d = S_WRITE_IMM;
            else if (is_mov_reg || is_mvn)      state_d = S_GET_B;
            else if (is_add || is_cmp || is_and) state_d = S_GET_A;
            else                                state_d = S_WAIT;
         end
         S_WRITE_IMM: begin
            bus.writenum = rn;
            bus.vsel     = 2'b01;
            bus.write    = 1'b1;
            state_d      = S_WAIT;
         end
         S_GET_A: begin
            bus.readnum = rn;
            bus.loada   = 1'b1;
            state_d     = S_GET_B;
         end
         S_GET_B: begin
            bus.readnum = rm;
            bus.loadb   = 1'b1;
            state_d     = S_ALU;
         end
         S_ALU: begin
            bus.shift = sh;
            bus.ALUop = (opcode == 3'b101) ? op : 2'b00;
            bus.asel  = is_mov_reg || is_mvn;
            if (is_cmp) begin
               bus.loads = 1'b1;
               state_d   = S_WAIT;
            end else begin
               bus.loadc = 1'b1;
               state_d   = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            bus.writenum = rd;
            bus.vsel     = 2'b11;
            bus.write    = 1'b1;
            state_d      = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_cpu_fsm_controller.sv
// Bench for cpu_fsm_controller: directed instruction scenarios plus random instructions.
// Expected controls come from a per-instruction micro-op list built from the instruction class.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_cpu_fsm_controller;

   typedef struct packed {
      logic       w;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       write;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] aluop;
   } ctl_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   ctl_t exp_q[$];
   ctl_t wait_c;

   cpu_fsm_controller_if bus();

   cpu_fsm_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic ctl_t sample();
      ctl_t c;
      c.w        = bus.w;
      c.readnum  = bus.readnum;
      c.writenum = bus.writenum;
      c.vsel     = bus.vsel;
      c.loada    = bus.loada;
      c.loadb    = bus.loadb;
      c.loadc    = bus.loadc;
      c.loads    = bus.loads;
      c.write    = bus.write;
      c.asel     = bus.asel;
      c.bsel     = bus.bsel;
      c.shift    = bus.shift;
      c.aluop    = bus.ALUop;
      return c;
   endfunction

   // Two's-complement value of the low 'bits' bits of word, as 16 bits.
   function automatic logic [15:0] sext(input logic [15:0] word, input int bits);
      int v;
      v = int'(word) & ((1 << bits) - 1);
      if (v >= (1 << (bits - 1))) v = v - (1 << bits);
      return v[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Micro-op list, one entry per edge after the start edge, ending back in idle.
   task automatic build_expected(input logic [15:0] word);
      logic [2:0] opc = word[15:13];
      logic [1:0] op  = word[12:11];
      ctl_t c;
      exp_q.delete();
      exp_q.push_back('0);                                  // decode cycle: nothing enabled
      if (opc == 3'b110 && op == 2'b10) begin               // MOV Rn,#imm8
         c = '0; c.writenum = word[10:8]; c.vsel = 2'b01; c.write = 1'b1;
         exp_q.push_back(c);
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         c = '0; c.readnum = word[2:0]; c.loadb = 1'b1;       // fetch Rm
         exp_q.push_back(c);
         c = '0; c.shift = word[4:3]; c.asel = 1'b1; c.loadc = 1'b1;
         c.aluop = (opc == 3'b101) ? op : 2'b00;
         exp_q.push_back(c);
         c = '0; c.writenum = word[7:5]; c.vsel = 2'b11; c.write = 1'b1;
         exp_q.push_back(c);
      end else if (opc == 3'b101) begin                       // ADD / CMP / AND
         c = '0; c.readnum = word[10:8]; c.loada = 1'b1;
         exp_q.push_back(c);
         c = '0; c.readnum = word[2:0]; c.loadb = 1'b1;
         exp_q.push_back(c);
         c = '0; c.shift = word[4:3]; c.aluop = op;
         if (op == 2'b01) c.loads = 1'b1; else c.loadc = 1'b1;
         exp_q.push_back(c);
         if (op != 2'b01) begin
            c = '0; c.writenum = word[7:5]; c.vsel = 2'b11; c.write = 1'b1;
            exp_q.push_back(c);
         end
      end
      exp_q.push_back(wait_c);
   endtask

   // Walk exp_q edge by edge; load/in are scrambled while busy to show they are ignored.
   task automatic follow(input string tag, input logic [15:0] word, input bit keep_s);
      int n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            bus.load = 1'b0;
            if (!keep_s) bus.s = 1'b0;
         end
         chk($sformatf("%s_ctl%0d", tag, k), 32'(sample()), 32'(exp_q[k]));
         chk($sformatf("%s_sx8_%0d", tag, k), 32'(bus.sximm8), 32'(sext(word, 8)));
         chk($sformatf("%s_sx5_%0d", tag, k), 32'(bus.sximm5), 32'(sext(word, 5)));
         if (k < n - 1) begin
            bus.load = 1'($urandom_range(0, 1));
            bus.in   = 16'($urandom);
         end else begin
            bus.load = 1'b0;
         end
      end
   endtask

   task automatic run_instr(input string tag, input logic [15:0] word, input bit keep_s);
      bus.in   = word;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      build_expected(word);
      follow(tag, word, keep_s);
   endtask

   initial begin
      logic [15:0] word;
      logic [15:0] rnd;
      int          cat;

      wait_c = '0;
      wait_c.w = 1'b1;

      // Reset held from time zero, checked mid-cycle and across an edge.
      rst_n = 1'b0; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'hFFFF;
      #3;
      chk("reset_ctl", 32'(sample()), 32'(wait_c));
      chk("reset_sx8", 32'(bus.sximm8), 32'h0);
      bus.load = 1'b1;
      #9;
      chk("reset_hold_sx8", 32'(bus.sximm8), 32'h0);
      bus.load = 1'b0;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 32'(sample()), 32'(wait_c));

      // MOV R0,#-3
      run_instr("mov_imm", 16'hD0FD, 1'b0);
      // ADD R2,R1,R0 LSL#1
      run_instr("add", 16'hA148, 1'b0);
      // CMP R3,R4
      run_instr("cmp", 16'hAB04, 1'b0);

      // Undefined word, with a load attempt during decode.
      bus.in = 16'hE000; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #1;
      chk("undef_decode", 32'(sample()), 32'h0);
      bus.s = 1'b0; bus.load = 1'b1; bus.in = 16'h1234;
      @(posedge clk); #1;
      chk("undef_back", 32'(sample()), 32'(wait_c));
      chk("undef_ir_kept", 32'(bus.sximm8), 32'h0);
      bus.load = 1'b0;

      // Held start re-executes the IR without reloading.
      run_instr("hold1", 16'hD7C4, 1'b1);
      bus.in = 16'h0000;
      follow("hold2", 16'hD7C4, 1'b0);

      // MVN R5,R6 aborted by reset during operand fetch.
      bus.in = 16'hB8A6; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0; bus.s = 1'b0;
      chk("mvn_decode", 32'(sample()), 32'h0);
      @(posedge clk); #1;
      chk("mvn_getb_loadb", 32'(bus.loadb), 32'h1);
      chk("mvn_getb_rm", 32'(bus.readnum), 32'h6);
      #2 rst_n = 1'b0;
      #1;
      chk("mvn_abort_ctl", 32'(sample()), 32'(wait_c));
      chk("mvn_abort_sx8", 32'(bus.sximm8), 32'h0);
      chk("mvn_abort_sx5", 32'(bus.sximm5), 32'h0);
      @(posedge clk); #1;
      chk("mvn_abort_edge", 32'(sample()), 32'(wait_c));
      #2 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_reset_idle%0d", i), 32'(sample()), 32'(wait_c));
      end
      bus.s = 1'b1;
      @(posedge clk); #1;
      bus.s = 1'b0;
      chk("zero_ir_decode", 32'(sample()), 32'h0);
      @(posedge clk); #1;
      chk("zero_ir_back", 32'(sample()), 32'(wait_c));

      // Random instructions across every class plus arbitrary words.
      for (int i = 0; i < 40; i++) begin
         cat = $urandom_range(0, 6);
         rnd = 16'($urandom);
         case (cat)
            0: word = {3'b110, 2'b10, rnd[10:0]};
            1: word = {3'b110, 2'b00, rnd[10:0]};
            2: word = {3'b101, 2'b11, rnd[10:0]};
            3: word = {3'b101, 2'b00, rnd[10:0]};
            4: word = {3'b101, 2'b01, rnd[10:0]};
            5: word = {3'b101, 2'b10, rnd[10:0]};
            default: word = rnd;
         endcase
         run_instr($sformatf("rnd%0d", i), word, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
